// File: rtl/custom_instr_pkg.sv
// rtl/custom_instr_pkg.sv - shared types for the coprocessor X-IF result path
//
// Purpose: result-entry record and per-ID commit state used by the result
// buffer and its FIFO.
// Ports: none (package).
package custom_instr_pkg;

  // Width of the X-IF instruction ID carried inside a buffered result.
  // xif_result_buf's ID_W parameter must match this value.
  localparam int XIF_ID_W = 4;

  typedef struct packed {
    logic [XIF_ID_W-1:0] id;
    logic [31:0]         data;
    logic [4:0]          rd;
    logic                we;
  } xif_res_entry_t;

  typedef enum logic [1:0] {
    NONE      = 2'd0,
    COMMITTED = 2'd1,
    KILLED    = 2'd2
  } commit_state_e;

endpackage

// File: rtl/xif_result_buf_if.sv
// rtl/xif_result_buf_if.sv - result/commit/X-IF result channel bundle
//
// Purpose: groups the execute-side result push, the X-IF commit strobe and
// the X-IF result channel of xif_result_buf.
// Modports:
//   master - environment side: drives res_*_i, commit_*_i, result_ready_i
//   slave  - buffer side: drives res_ready_o, result_*_o, count_o, drop_o
interface xif_result_buf_if #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             res_valid_i;
  logic             res_ready_o;
  logic [ID_W-1:0]  res_id_i;
  logic [31:0]      res_data_i;
  logic [4:0]       res_rd_i;
  logic             res_we_i;

  logic             commit_valid_i;
  logic [ID_W-1:0]  commit_id_i;
  logic             commit_kill_i;

  logic             result_valid_o;
  logic             result_ready_i;
  logic [ID_W-1:0]  result_id_o;
  logic [31:0]      result_data_o;
  logic [4:0]       result_rd_o;
  logic             result_we_o;

  logic [CNT_W-1:0] count_o;
  logic             drop_o;

  modport master (
    output res_valid_i, res_id_i, res_data_i, res_rd_i, res_we_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output result_ready_i,
    input  res_ready_o, result_valid_o, result_id_o, result_data_o,
    input  result_rd_o, result_we_o, count_o, drop_o
  );

  modport slave (
    input  res_valid_i, res_id_i, res_data_i, res_rd_i, res_we_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  result_ready_i,
    output res_ready_o, result_valid_o, result_id_o, result_data_o,
    output result_rd_o, result_we_o, count_o, drop_o
  );

endinterface

// File: rtl/xif_result_buf_res_fifo.sv
// rtl/xif_result_buf_res_fifo.sv - synchronous FIFO of buffered result entries
//
// Purpose: in-order storage of xif_res_entry_t; the head entry is visible
// combinationally on rdata_o.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   push_i, wdata_i    write wdata_i at the tail (ignored when full)
//   pop_i              drop the head entry (ignored when empty)
//   rdata_o            current head entry
//   full_o, empty_o    occupancy flags
//   count_o            number of occupied entries
module res_fifo
  import custom_instr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           push_i,
  input  xif_res_entry_t wdata_i,
  input  logic           pop_i,
  output xif_res_entry_t rdata_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [CNT_W-1:0] count_o
);

  xif_res_entry_t   mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem[rd_ptr];
  assign count_o = count;

  // Storage needs no reset; only entries below count are ever read out.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  // Pointers are exactly log2(DEPTH) bits and wrap on overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xif_result_buf.sv
// rtl/xif_result_buf.sv - commit-gated result buffer driving the X-IF result channel
//
// Purpose: buffers finished results in push order, tracks commit/kill per
// instruction ID, emits a result only after its ID is committed and silently
// discards results of killed IDs.
// Ports:
//   clk_i   clock
//   rst_ni  async active-low reset
//   xif     slave side of xif_result_buf_if (result push, commit strobe,
//           X-IF result channel, count_o, drop_o)
module xif_result_buf
  import custom_instr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = XIF_ID_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  xif_result_buf_if.slave xif
);

  localparam int NIDS  = 2 ** ID_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  commit_state_e    state_q [NIDS];

  xif_res_entry_t   push_entry;
  xif_res_entry_t   head;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic             hs_pop;
  logic             kill_pop;
  logic             head_commit;
  logic [ID_W-1:0]  head_id;
  commit_state_e    head_state;

  logic             out_valid_q;
  logic [ID_W-1:0]  out_id_q;
  logic [31:0]      out_data_q;
  logic [4:0]       out_rd_q;
  logic             out_we_q;
  logic             drop_q;

  // No full-bypass: a pop in the same cycle does not make room for a push.
  assign push = xif.res_valid_i && !full;

  assign push_entry.id   = xif.res_id_i;
  assign push_entry.data = xif.res_data_i;
  assign push_entry.rd   = xif.res_rd_i;
  assign push_entry.we   = xif.res_we_i;

  res_fifo #(
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign head_id    = head.id;
  assign head_state = state_q[head_id];

  // The head is only evaluated while no result is on offer, so an offered
  // result stays put until the core takes it. A commit landing in the same
  // cycle is seen through state_q on the following evaluation.
  assign hs_pop      = out_valid_q && xif.result_ready_i;
  assign head_commit = !out_valid_q && !empty && (head_state == COMMITTED);
  assign kill_pop    = !out_valid_q && !empty && (head_state == KILLED);
  assign pop         = hs_pop || kill_pop;

  // Commit table. A repeated commit/kill for a decided ID is ignored, except
  // when that ID is being cleared by a pop in the same cycle: then the ID has
  // been reused by a new instruction and its commit must not be lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NIDS; i++) begin
        state_q[i] <= NONE;
      end
    end else begin
      for (int i = 0; i < NIDS; i++) begin
        if (xif.commit_valid_i && (xif.commit_id_i == ID_W'(i)) &&
            ((state_q[i] == NONE) || (pop && (head_id == ID_W'(i))))) begin
          state_q[i] <= xif.commit_kill_i ? KILLED : COMMITTED;
        end else if (pop && (head_id == ID_W'(i))) begin
          state_q[i] <= NONE;
        end
      end
    end
  end

  // Registered result channel and drop pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= kill_pop;
      if (hs_pop) begin
        out_valid_q <= 1'b0;
        out_id_q    <= '0;
        out_data_q  <= '0;
        out_rd_q    <= '0;
        out_we_q    <= 1'b0;
      end else if (head_commit) begin
        out_valid_q <= 1'b1;
        out_id_q    <= head_id;
        out_data_q  <= head.data;
        out_rd_q    <= head.rd;
        out_we_q    <= head.we;
      end
    end
  end

  assign xif.res_ready_o    = !full;
  assign xif.result_valid_o = out_valid_q;
  assign xif.result_id_o    = out_id_q;
  assign xif.result_data_o  = out_data_q;
  assign xif.result_rd_o    = out_rd_q;
  assign xif.result_we_o    = out_we_q;
  assign xif.count_o        = count;
  assign xif.drop_o         = drop_q;

endmodule

// File: tb/tb_xif_result_buf.sv
// tb/tb_xif_result_buf.sv - self-checking bench for xif_result_buf
module tb_xif_result_buf;

  localparam int DEPTH = 4;
  localparam int ID_W  = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  xif_result_buf_if #(.ID_W(ID_W), .DEPTH(DEPTH)) bus ();

  xif_result_buf #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .xif    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.res_valid_i    = 1'b0;
    bus.res_id_i       = '0;
    bus.res_data_i     = '0;
    bus.res_rd_i       = '0;
    bus.res_we_i       = 1'b0;
    bus.commit_valid_i = 1'b0;
    bus.commit_id_i    = '0;
    bus.commit_kill_i  = 1'b0;
  endtask

  // Each helper drives for one clock edge and returns at the next falling edge.
  task automatic push(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd, input logic we);
    bus.res_valid_i = 1'b1;
    bus.res_id_i    = id;
    bus.res_data_i  = data;
    bus.res_rd_i    = rd;
    bus.res_we_i    = we;
    @(negedge clk);
    bus.res_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    bus.commit_valid_i = 1'b1;
    bus.commit_id_i    = id;
    bus.commit_kill_i  = kill;
    @(negedge clk);
    bus.commit_valid_i = 1'b0;
    bus.commit_kill_i  = 1'b0;
  endtask

  // Reference model for the random phase: instructions in issue order.
  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    bit          kill;
  } instr_t;

  instr_t iq[$];
  bit     busy_id [16];
  int     n_pushed;
  int     n_decided;
  int     mcount;

  task automatic retire(input bit via_drop);
    instr_t f;
    chk("rnd_model_nonempty", 64'(iq.size() != 0), 64'd1);
    if (iq.size() == 0) return;
    f = iq.pop_front();
    chk("rnd_fate", 64'(f.kill), 64'(via_drop));
    chk("rnd_was_pushed", 64'(n_pushed > 0), 64'd1);
    if (!via_drop) begin
      chk("rnd_id", 64'(bus.result_id_o), 64'(f.id));
      chk("rnd_data", 64'(bus.result_data_o), 64'(f.data));
      chk("rnd_rd", 64'(bus.result_rd_o), 64'(f.rd));
      chk("rnd_we", 64'(bus.result_we_o), 64'(f.we));
    end
    busy_id[f.id] = 1'b0;
    if (n_pushed > 0) n_pushed--;
    if (n_decided > 0) n_decided--;
    mcount--;
  endtask

  initial begin
    int     got_n;
    bit     ready_pending;
    bit     issue_on;
    instr_t ni;
    logic [3:0] cand;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    bus.result_ready_i = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid", 64'(bus.result_valid_o), 64'd0);
    chk("rst_ready", 64'(bus.res_ready_o), 64'd1);
    chk("rst_count", 64'(bus.count_o), 64'd0);
    chk("rst_drop", 64'(bus.drop_o), 64'd0);
    chk("rst_data", 64'(bus.result_data_o), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: commit before push
    commit(4'd3, 1'b0);
    push(4'd3, 32'h0000_00A5, 5'd7, 1'b1);
    chk("t1_count_after_push", 64'(bus.count_o), 64'd1);
    @(negedge clk);
    chk("t1_valid", 64'(bus.result_valid_o), 64'd1);
    chk("t1_id", 64'(bus.result_id_o), 64'd3);
    chk("t1_data", 64'(bus.result_data_o), 64'hA5);
    chk("t1_rd", 64'(bus.result_rd_o), 64'd7);
    chk("t1_we", 64'(bus.result_we_o), 64'd1);
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    chk("t1_valid_after_pop", 64'(bus.result_valid_o), 64'd0);
    chk("t1_count_after_pop", 64'(bus.count_o), 64'd0);

    // 2: commit two cycles after push, then back-pressure
    push(4'd5, 32'h0000_1234, 5'd2, 1'b0);
    chk("t2_wait0", 64'(bus.result_valid_o), 64'd0);
    @(negedge clk);
    chk("t2_wait1", 64'(bus.result_valid_o), 64'd0);
    commit(4'd5, 1'b0);
    chk("t2_commit_edge", 64'(bus.result_valid_o), 64'd0);
    @(negedge clk);
    chk("t2_valid", 64'(bus.result_valid_o), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t2_hold_valid", 64'(bus.result_valid_o), 64'd1);
      chk("t2_hold_id", 64'(bus.result_id_o), 64'd5);
      chk("t2_hold_data", 64'(bus.result_data_o), 64'h1234);
      chk("t2_hold_rd", 64'(bus.result_rd_o), 64'd2);
    end
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    chk("t2_count_after_pop", 64'(bus.count_o), 64'd0);

    // 3: kill after push
    push(4'd2, 32'hDEAD_0002, 5'd1, 1'b1);
    chk("t3_count_before", 64'(bus.count_o), 64'd1);
    commit(4'd2, 1'b1);
    chk("t3_no_valid", 64'(bus.result_valid_o), 64'd0);
    @(negedge clk);
    chk("t3_drop", 64'(bus.drop_o), 64'd1);
    chk("t3_count_after", 64'(bus.count_o), 64'd0);
    chk("t3_no_valid2", 64'(bus.result_valid_o), 64'd0);
    @(negedge clk);
    chk("t3_drop_once", 64'(bus.drop_o), 64'd0);

    // 4: fill to DEPTH, then commit in order
    for (int i = 0; i < 4; i++) begin
      cand = 4'(i);
      push(cand, 32'h100 + 32'(i), 5'(i + 8), 1'b1);
    end
    chk("t4_full_ready", 64'(bus.res_ready_o), 64'd0);
    chk("t4_full_count", 64'(bus.count_o), 64'd4);
    push(4'd9, 32'hBAD, 5'd1, 1'b1);
    chk("t4_no_overflow", 64'(bus.count_o), 64'd4);
    got_n = 0;
    ready_pending = 1'b0;
    bus.result_ready_i = 1'b1;
    for (int c = 0; c < 40 && got_n < 4; c++) begin
      if (ready_pending) begin
        chk("t4_ready_back", 64'(bus.res_ready_o), 64'd1);
        ready_pending = 1'b0;
      end
      bus.commit_valid_i = (c < 4);
      bus.commit_id_i    = 4'(c);
      if (bus.result_valid_o) begin
        chk("t4_order", 64'(bus.result_id_o), 64'(got_n));
        chk("t4_data", 64'(bus.result_data_o), 64'h100 + 64'(got_n));
        if (got_n == 0) ready_pending = 1'b1;
        got_n++;
      end
      @(negedge clk);
    end
    bus.commit_valid_i = 1'b0;
    bus.result_ready_i = 1'b0;
    chk("t4_all_emitted", 64'(got_n), 64'd4);
    chk("t4_count_end", 64'(bus.count_o), 64'd0);

    // 5: reset mid-stream
    commit(4'd1, 1'b0);
    push(4'd1, 32'h0000_0111, 5'd3, 1'b1);
    @(negedge clk);
    chk("t5_valid_before_rst", 64'(bus.result_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(bus.result_valid_o), 64'd0);
    chk("t5_rst_count", 64'(bus.count_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(4'd1, 32'h0000_0222, 5'd4, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk("t5_no_emit", 64'(bus.result_valid_o), 64'd0);
      @(negedge clk);
    end
    chk("t5_count_held", 64'(bus.count_o), 64'd1);
    commit(4'd1, 1'b1);
    @(negedge clk);
    chk("t5_cleanup_drop", 64'(bus.drop_o), 64'd1);
    chk("t5_cleanup_count", 64'(bus.count_o), 64'd0);

    // 6: handshake and re-commit of the same ID in one cycle
    commit(4'd4, 1'b0);
    push(4'd4, 32'h0000_0444, 5'd5, 1'b1);
    @(negedge clk);
    chk("t6_valid", 64'(bus.result_valid_o), 64'd1);
    bus.result_ready_i = 1'b1;
    commit(4'd4, 1'b0);
    bus.result_ready_i = 1'b0;
    chk("t6_popped", 64'(bus.count_o), 64'd0);
    push(4'd4, 32'h0000_0555, 5'd6, 1'b0);
    chk("t6_push_count", 64'(bus.count_o), 64'd1);
    @(negedge clk);
    chk("t6_reuse_valid", 64'(bus.result_valid_o), 64'd1);
    chk("t6_reuse_data", 64'(bus.result_data_o), 64'h555);
    bus.result_ready_i = 1'b1;
    @(negedge clk);
    bus.result_ready_i = 1'b0;
    chk("t6_count_end", 64'(bus.count_o), 64'd0);

    // Random phase: in-order issue, push and commit/kill with random timing
    for (int i = 0; i < 16; i++) busy_id[i] = 1'b0;
    n_pushed  = 0;
    n_decided = 0;
    mcount    = 0;
    issue_on  = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      if (c == 800) issue_on = 1'b0;
      if (!issue_on && iq.size() == 0) break;
      if (bus.drop_o) retire(1'b1);
      chk("rnd_count", 64'(bus.count_o), 64'(mcount));
      idle_inputs();
      bus.result_ready_i = issue_on ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bus.result_valid_o && bus.result_ready_i) retire(1'b0);
      if (issue_on && iq.size() < 6 && $urandom_range(0, 1) == 1) begin
        for (int t = 0; t < 32; t++) begin
          cand = 4'($urandom_range(0, 15));
          if (!busy_id[cand]) begin
            ni.id   = cand;
            ni.data = $urandom;
            ni.rd   = 5'($urandom_range(0, 31));
            ni.we   = 1'($urandom_range(0, 1));
            ni.kill = ($urandom_range(0, 3) == 0);
            busy_id[cand] = 1'b1;
            iq.push_back(ni);
            break;
          end
        end
      end
      if (n_decided < iq.size() && (!issue_on || $urandom_range(0, 2) != 0)) begin
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = iq[n_decided].id;
        bus.commit_kill_i  = iq[n_decided].kill;
        n_decided++;
      end
      if (n_pushed < iq.size() && bus.res_ready_o && (!issue_on || $urandom_range(0, 2) != 0)) begin
        bus.res_valid_i = 1'b1;
        bus.res_id_i    = iq[n_pushed].id;
        bus.res_data_i  = iq[n_pushed].data;
        bus.res_rd_i    = iq[n_pushed].rd;
        bus.res_we_i    = iq[n_pushed].we;
        n_pushed++;
        mcount++;
      end
      @(negedge clk);
    end
    idle_inputs();
    bus.result_ready_i = 1'b0;
    chk("rnd_drained", 64'(iq.size()), 64'd0);
    @(negedge clk);
    chk("rnd_final_count", 64'(bus.count_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
